// File: rtl/mem_arbiter.sv
// mem_arbiter
// Merges the instruction-cache (IM_*) and data-cache (DM_*) refill request
// streams onto one shared external memory port. Each granted request is
// registered, issued to memory for as long as memory takes to answer, and
// completed with a one-cycle ready pulse back to the requesting cache. A
// watchdog aborts a request that memory never answers.
//
// Ports:
//   clock, reset                  system clock, async active-high reset
//   IM_enable/read/write/address  instruction-side request (held until IM_ready)
//   IM_out, IM_ready              instruction-side read data, completion pulse
//   DM_enable/read/write/address  data-side request (held until DM_ready)
//   DM_in                         data-side write data
//   DM_out, DM_ready              data-side read data, completion pulse
//   MEM_enable/read/write         memory request, high for the whole BUSY state
//   MEM_address, MEM_in           memory address and write data
//   MEM_out, MEM_ready            memory read data and completion
//   bus_error                     sticky watchdog-abort flag
//
// State | meaning
// IDLE  | waiting for a request; arbitrates round-robin on a tie
// BUSY  | request registers driven onto the memory port
// RESP  | one-cycle ready pulse to the granted side
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IM_enable,
  input  logic                  IM_read,
  input  logic                  IM_write,
  input  logic [ADDR_WIDTH-1:0] IM_address,
  output logic [DATA_WIDTH-1:0] IM_out,
  output logic                  IM_ready,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  output logic                  DM_ready,
  output logic                  MEM_enable,
  output logic                  MEM_read,
  output logic                  MEM_write,
  output logic [ADDR_WIDTH-1:0] MEM_address,
  output logic [DATA_WIDTH-1:0] MEM_in,
  input  logic [DATA_WIDTH-1:0] MEM_out,
  input  logic                  MEM_ready,
  output logic                  bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

  state_t                 state_q, state_d;
  logic                   side_q, side_d;           // 1 = DM, 0 = IM
  logic                   last_grant_q, last_grant_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   berr_q, berr_d;
  logic [DATA_WIDTH-1:0]  im_out_q, im_out_d;
  logic [DATA_WIDTH-1:0]  dm_out_q, dm_out_d;
  logic                   grant_dm;
  logic                   req_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      side_q       <= 1'b0;
      last_grant_q <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      berr_q       <= 1'b0;
      im_out_q     <= '0;
      dm_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      berr_q       <= berr_d;
      im_out_q     <= im_out_d;
      dm_out_q     <= dm_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    berr_d       = berr_q;
    im_out_d     = im_out_q;
    dm_out_d     = dm_out_q;
    // On a tie DM wins unless DM had the previous grant.
    grant_dm     = DM_enable && (!IM_enable || !last_grant_q);
    // Read wins over write; a request with neither is issued as a read.
    req_rd       = grant_dm ? (DM_read || !DM_write) : (IM_read || !IM_write);

    case (state_q)
      S_IDLE: begin
        if (IM_enable || DM_enable) begin
          side_d       = grant_dm;
          last_grant_d = grant_dm;
          rd_d         = req_rd;
          wr_d         = !req_rd;
          addr_d       = grant_dm ? DM_address : IM_address;
          wdata_d      = grant_dm ? DM_in : '0;
          cnt_d        = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (MEM_ready) begin
          if (rd_q) begin
            if (side_q) dm_out_d = MEM_out;
            else        im_out_d = MEM_out;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_d == TO_CNT)) begin
            berr_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic busy;
  logic resp;
  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);

  assign MEM_enable  = busy;
  assign MEM_read    = busy && rd_q;
  assign MEM_write   = busy && wr_q;
  assign MEM_address = busy ? addr_q  : '0;
  assign MEM_in      = busy ? wdata_q : '0;
  assign IM_ready    = resp && !side_q;
  assign DM_ready    = resp && side_q;
  assign IM_out      = im_out_q;
  assign DM_out      = dm_out_q;
  assign bus_error   = berr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        IM_enable = 1'b0, IM_read = 1'b0, IM_write = 1'b0;
  logic [31:0] IM_address = '0;
  logic [31:0] IM_out;
  logic        IM_ready;
  logic        DM_enable = 1'b0, DM_read = 1'b0, DM_write = 1'b0;
  logic [31:0] DM_address = '0, DM_in = '0;
  logic [31:0] DM_out;
  logic        DM_ready;
  logic        MEM_enable, MEM_read, MEM_write;
  logic [31:0] MEM_address, MEM_in;
  logic [31:0] MEM_out = '0;
  logic        MEM_ready;
  logic        bus_error;

  int nvec = 0;
  int nerr = 0;
  logic mem_auto = 1'b1;
  int   mem_wait = 0;
  int   busy_cnt = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
    .IM_address(IM_address), .IM_out(IM_out), .IM_ready(IM_ready),
    .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
    .DM_address(DM_address), .DM_in(DM_in), .DM_out(DM_out), .DM_ready(DM_ready),
    .MEM_enable(MEM_enable), .MEM_read(MEM_read), .MEM_write(MEM_write),
    .MEM_address(MEM_address), .MEM_in(MEM_in), .MEM_out(MEM_out),
    .MEM_ready(MEM_ready), .bus_error(bus_error)
  );

  // Memory model: answers after mem_wait wait cycles of MEM_enable.
  initial begin
    MEM_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (MEM_enable && mem_auto && busy_cnt >= mem_wait) MEM_ready = 1'b1;
      else MEM_ready = 1'b0;
      if (MEM_enable) busy_cnt++;
      else busy_cnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; IM_enable = 1'b0; DM_enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    nvec++; if (MEM_enable !== 1'b0) begin nerr++; $display("FAIL reset_mem_enable got %b want 0", MEM_enable); end
    nvec++; if ({IM_ready, DM_ready} !== 2'b00) begin nerr++; $display("FAIL reset_ready got %b want 00", {IM_ready, DM_ready}); end
    nvec++; if (IM_out !== 32'h0 || DM_out !== 32'h0) begin nerr++; $display("FAIL reset_data got %h/%h want 0/0", IM_out, DM_out); end
    nvec++; if (bus_error !== 1'b0) begin nerr++; $display("FAIL reset_bus_error got %b want 0", bus_error); end
    nvec++; if (MEM_address !== 32'h0) begin nerr++; $display("FAIL reset_mem_address got %h want 0", MEM_address); end
    reset = 1'b0;
  endtask

  task automatic test_dm_read();
    int en_cyc = 0, dmr = 0, imr = 0;
    logic ok = 1'b1;
    @(negedge clock);
    MEM_out = 32'hCAFEBABE; mem_wait = 2; mem_auto = 1'b1;
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'h100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (MEM_enable) begin
        en_cyc++;
        if (MEM_address !== 32'h100 || MEM_read !== 1'b1 || MEM_write !== 1'b0) ok = 1'b0;
      end
      if (DM_ready) begin dmr++; DM_enable = 1'b0; end
      if (IM_ready) imr++;
    end
    nvec++; if (en_cyc !== 3) begin nerr++; $display("FAIL dm_read_busy_cycles got %0d want 3", en_cyc); end
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL dm_read_mem_port got bad addr/read want 0x100 read"); end
    nvec++; if (dmr !== 1) begin nerr++; $display("FAIL dm_read_ready_pulses got %0d want 1", dmr); end
    nvec++; if (imr !== 0) begin nerr++; $display("FAIL dm_read_im_ready got %0d want 0", imr); end
    nvec++; if (DM_out !== 32'hCAFEBABE) begin nerr++; $display("FAIL dm_read_data got %h want cafebabe", DM_out); end
  endtask

  task automatic test_tie();
    int dm_cyc = -1, im_cyc = -1;
    logic [31:0] first_addr = '0;
    logic seen = 1'b0;
    do_reset();
    @(negedge clock);
    MEM_out = 32'h5A5A0001; mem_wait = 0; mem_auto = 1'b1;
    IM_enable = 1'b1; IM_read = 1'b1; IM_write = 1'b0; IM_address = 32'h40;
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'h80;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (MEM_enable && !seen) begin seen = 1'b1; first_addr = MEM_address; end
      if (DM_ready) begin dm_cyc = c; DM_enable = 1'b0; end
      if (IM_ready) begin im_cyc = c; IM_enable = 1'b0; end
    end
    nvec++; if (first_addr !== 32'h80) begin nerr++; $display("FAIL tie_first_grant got %h want 80", first_addr); end
    nvec++; if (dm_cyc < 0 || im_cyc - dm_cyc !== 3) begin nerr++; $display("FAIL tie_ready_gap got dm=%0d im=%0d want gap 3", dm_cyc, im_cyc); end
    nvec++; if (IM_out !== 32'h5A5A0001 || DM_out !== 32'h5A5A0001) begin nerr++; $display("FAIL tie_data got %h/%h want 5a5a0001", IM_out, DM_out); end
  endtask

  task automatic test_dm_write();
    int en_cyc = 0, dmr = 0;
    logic ok = 1'b1;
    @(negedge clock);
    MEM_out = 32'hDEADDEAD; mem_wait = 2;
    DM_enable = 1'b1; DM_read = 1'b0; DM_write = 1'b1; DM_address = 32'h200; DM_in = 32'h12345678;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (MEM_enable) begin
        en_cyc++;
        if (MEM_in !== 32'h12345678 || MEM_write !== 1'b1 || MEM_read !== 1'b0 || MEM_address !== 32'h200) ok = 1'b0;
        DM_in = DM_in + 32'h1111;
      end
      if (DM_ready) begin dmr++; DM_enable = 1'b0; end
    end
    nvec++; if (en_cyc !== 3) begin nerr++; $display("FAIL dm_write_busy_cycles got %0d want 3", en_cyc); end
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL dm_write_mem_in got changed want 12345678 write"); end
    nvec++; if (dmr !== 1) begin nerr++; $display("FAIL dm_write_ready got %0d want 1", dmr); end
    nvec++; if (DM_out !== 32'h5A5A0001) begin nerr++; $display("FAIL dm_write_dm_out got %h want 5a5a0001", DM_out); end
  endtask

  task automatic test_timeout();
    int en_cyc = 0, dmr = 0, imr = 0;
    @(negedge clock);
    mem_auto = 1'b0; MEM_out = 32'h99999999;
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'h300;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (MEM_enable) en_cyc++;
      if (DM_ready) begin dmr++; DM_enable = 1'b0; end
    end
    nvec++; if (en_cyc !== 4) begin nerr++; $display("FAIL timeout_busy_cycles got %0d want 4", en_cyc); end
    nvec++; if (dmr !== 1) begin nerr++; $display("FAIL timeout_ready got %0d want 1", dmr); end
    nvec++; if (bus_error !== 1'b1) begin nerr++; $display("FAIL timeout_bus_error got %b want 1", bus_error); end
    nvec++; if (DM_out !== 32'h5A5A0001) begin nerr++; $display("FAIL timeout_dm_out got %h want 5a5a0001", DM_out); end
    mem_auto = 1'b1; mem_wait = 0; MEM_out = 32'h0BADF00D;
    IM_enable = 1'b1; IM_read = 1'b1; IM_write = 1'b0; IM_address = 32'h500;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (IM_ready) begin imr++; IM_enable = 1'b0; end
    end
    nvec++; if (imr !== 1) begin nerr++; $display("FAIL after_timeout_ready got %0d want 1", imr); end
    nvec++; if (IM_out !== 32'h0BADF00D) begin nerr++; $display("FAIL after_timeout_im_out got %h want 0badf00d", IM_out); end
    nvec++; if (bus_error !== 1'b1) begin nerr++; $display("FAIL bus_error_sticky got %b want 1", bus_error); end
  endtask

  task automatic test_reset_mid();
    int dmr = 0, en_cyc = 0;
    logic [31:0] first_addr = '0;
    logic seen = 1'b0;
    @(negedge clock);
    mem_auto = 1'b1; mem_wait = 0; MEM_out = 32'h77770000;
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'h600;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (DM_ready) DM_enable = 1'b0;
    end
    nvec++; if (DM_out !== 32'h77770000) begin nerr++; $display("FAIL mid_pre_data got %h want 77770000", DM_out); end
    mem_auto = 1'b0; DM_enable = 1'b1; DM_address = 32'h700;
    repeat (2) @(negedge clock);
    nvec++; if (MEM_enable !== 1'b1) begin nerr++; $display("FAIL mid_in_busy got %b want 1", MEM_enable); end
    #2 reset = 1'b1;
    #1;
    nvec++; if (MEM_enable !== 1'b0 || MEM_read !== 1'b0) begin nerr++; $display("FAIL mid_async_mem got %b%b want 00", MEM_enable, MEM_read); end
    nvec++; if (DM_out !== 32'h0 || IM_out !== 32'h0 || DM_ready !== 1'b0) begin nerr++; $display("FAIL mid_async_outputs got %h/%h/%b want 0", DM_out, IM_out, DM_ready); end
    nvec++; if (bus_error !== 1'b0) begin nerr++; $display("FAIL mid_async_bus_error got %b want 0", bus_error); end
    @(negedge clock);
    reset = 1'b0; DM_enable = 1'b0; mem_auto = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (DM_ready) dmr++;
      if (MEM_enable) en_cyc++;
    end
    nvec++; if (dmr !== 0 || en_cyc !== 0) begin nerr++; $display("FAIL mid_dropped got ready=%0d busy=%0d want 0/0", dmr, en_cyc); end
    IM_enable = 1'b1; IM_read = 1'b1; IM_address = 32'h10;
    DM_enable = 1'b1; DM_read = 1'b1; DM_address = 32'h20;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      if (MEM_enable && !seen) begin seen = 1'b1; first_addr = MEM_address; end
      if (DM_ready) DM_enable = 1'b0;
      if (IM_ready) IM_enable = 1'b0;
    end
    nvec++; if (first_addr !== 32'h20) begin nerr++; $display("FAIL mid_first_tie got %h want 20", first_addr); end
  endtask

  task automatic test_alternate();
    logic [31:0] grants [6];
    int n = 0;
    logic prev_en = 1'b0;
    logic [31:0] want;
    for (int k = 0; k < 6; k++) grants[k] = '0;
    do_reset();
    @(negedge clock);
    mem_wait = 1; mem_auto = 1'b1;
    IM_enable = 1'b1; IM_read = 1'b1; IM_write = 1'b0; IM_address = 32'hA0;
    DM_enable = 1'b1; DM_read = 1'b1; DM_write = 1'b0; DM_address = 32'hB0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clock);
      if (MEM_enable && !prev_en) begin grants[n] = MEM_address; n++; end
      prev_en = MEM_enable;
    end
    IM_enable = 1'b0; DM_enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      want = (k % 2 == 0) ? 32'hB0 : 32'hA0;
      nvec++;
      if (grants[k] !== want) begin nerr++; $display("FAIL alternate_grant%0d got %h want %h", k, grants[k], want); end
    end
    repeat (4) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_dm_read();
    test_tie();
    test_dm_write();
    test_timeout();
    test_reset_mid();
    test_alternate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sits directly downstream of the CPU's instruction-cache and data-cache system ports (IM_*/DM_*). It merges the two miss/refill request streams onto one shared external memory port with a variable-latency ready handshake. Each request is registered, issued to memory, and completed with a one-cycle ready pulse back to the originating cache. A watchdog aborts requests that never complete.

Parameters:
ADDR_WIDTH, 32, width of the address buses
DATA_WIDTH, 32, width of the data buses
TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog
CNT_WIDTH, 8, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
IM_enable  in  1  instruction-side request strobe, held until IM_ready
IM_read  in  1  instruction-side read
IM_write  in  1  instruction-side write; data forwarded as 0
IM_address  in  ADDR_WIDTH  instruction-side address
IM_out  out  DATA_WIDTH  instruction-side read data
IM_ready  out  1  instruction-side completion pulse
DM_enable  in  1  data-side request strobe, held until DM_ready
DM_read  in  1  data-side read
DM_write  in  1  data-side write
DM_address  in  ADDR_WIDTH  data-side address
DM_in  in  DATA_WIDTH  data-side write data
DM_out  out  DATA_WIDTH  data-side read data
DM_ready  out  1  data-side completion pulse
MEM_enable  out  1  memory request, high for the whole BUSY state
MEM_read  out  1  memory read
MEM_write  out  1  memory write
MEM_address  out  ADDR_WIDTH  memory address
MEM_in  out  DATA_WIDTH  memory write data
MEM_out  in  DATA_WIDTH  memory read data, valid when MEM_ready=1
MEM_ready  in  1  memory completion, may be high in the first BUSY cycle
bus_error  out  1  sticky watchdog-abort flag

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including IM_out, DM_out and bus_error.
  - last_grant is set to I, so DM wins the first tie.
  - Watchdog counter is cleared.
  - Applies mid-transaction: any in-flight request is dropped with no ready pulse.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If only one enable is high, grant that side.
  - If both are high, grant the side opposite last_grant (round-robin), then update last_grant.
  - On grant: latch side, read, write, address and write data (DM_in, or 0 for IM) into request registers, clear the counter, and go to BUSY.
  - With no enable high, stay in IDLE.
- BUSY:
  - MEM_enable=1; MEM_read/write/address/in are driven from the request registers, not the live inputs.
  - When MEM_ready=1 at an edge: if the request is a read, capture MEM_out into the granted side's output register; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (and TIMEOUT≠0): set bus_error, leave the output data register unchanged, and go to RESP.
- RESP:
  - The granted side's ready is 1 for exactly this one cycle; MEM_enable=0.
  - Next state is always IDLE. Requester enables are ignored in RESP.
- Outputs:
  - IM_out and DM_out hold their last captured value between transactions.
  - A write request never alters IM_out or DM_out.
- Latency: enable sampled at edge N gives MEM_enable in cycle N+1. With MEM_ready=1 in N+1, ready is high in cycle N+2. Minimum is 3 cycles from request to ready; each extra memory wait cycle adds 1.
- Both read and write asserted: treat as read (read wins). Enable with neither read nor write: issue a read.
- A requester holding enable across its ready cycle is re-arbitrated as a new request in the following IDLE cycle.
- bus_error clears only on reset.

Test Plan:
- Single DM read at address 0x100; memory returns 0xCAFEBABE with 2 wait cycles -> MEM_enable high for 3 cycles with MEM_address=0x100 and MEM_read=1; DM_ready pulses once; DM_out=0xCAFEBABE; IM_ready stays 0.
- IM and DM enabled in the same cycle after reset, zero-wait memory -> DM served first. IM granted in the IDLE cycle after DM's RESP. IM_ready is high exactly 3 cycles after DM_ready.
- DM write of 0x12345678 to address 0x200 while DM_in changes during BUSY -> MEM_in stays 0x12345678 throughout; DM_out is unchanged.
- TIMEOUT=4 with MEM_ready held at 0 -> after 4 BUSY cycles bus_error=1 and a single ready pulse; the next request still completes normally and bus_error stays 1.
- Reset asserted in the middle of BUSY -> MEM_enable, ready outputs and data outputs go to 0 immediately without waiting for a clock edge. After release the arbiter returns to IDLE and the first tie goes to DM.
- Continuous IM and DM requests for 6 transactions -> grants strictly alternate D, I, D, I, D, I.
